// File: rtl/alu_mem_decode_unit.sv
// Execute/memory/write-select slice of the 8-bit single-cycle processor:
// ALU with immediate mux, 256x8 data memory addressed by the ALU result, and destination decoder.
module alu_mem_decode_unit #(
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rx,
  input  logic [DW-1:0] ry,
  input  logic [DW-1:0] imm,
  input  logic          imm_sel,
  input  logic [1:0]    alu_op,
  input  logic          rd_sel,
  input  logic [2:0]    d_sel,
  input  logic          mem_we,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] sum_out,
  output logic [DW-1:0] and_out,
  output logic          zero,
  output logic [DW-1:0] alu_res,
  output logic [DW-1:0] mem_data,
  output logic [DW-1:0] wb_data,
  output logic [7:0]    save_en
);

  logic [DW-1:0] yEff;
  logic [DW-1:0] mem_q [DEPTH];

  assign yEff    = imm_sel ? imm : ry;
  assign sum_out = rx + yEff;
  assign and_out = rx & yEff;
  assign zero    = (rx == yEff);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'd0:    alu_res = and_out;
      2'd1:    alu_res = sum_out;
      2'd2:    alu_res = {zero, {(DW-1){1'b0}}};
      default: alu_res = yEff;
    endcase
  end

  // Reset clears every word and takes priority over a write requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[alu_res] <= mem_wdata;
    end
  end

  assign mem_data = mem_q[alu_res];
  assign wb_data  = rd_sel ? mem_data : alu_res;

  // No destination is enabled while reset is held, so no register is written during reset.
  always_comb begin
    save_en = 8'h00;
    if (!rst) begin
      save_en[d_sel] = 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_mem_decode_unit.sv
// Self-checking bench for alu_mem_decode_unit: ALU vector table, memory/reset sequences,
// decoder sweep and randomized traffic against a behavioural model.
module tb_alu_mem_decode_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx, ry, imm, mem_wdata;
  logic       imm_sel, rd_sel, mem_we;
  logic [1:0] alu_op;
  logic [2:0] d_sel;
  logic [7:0] sum_out, and_out, alu_res, mem_data, wb_data, save_en;
  logic       zero;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] modelMem [256];

  typedef struct {
    logic [7:0] rx;
    logic [7:0] ry;
    logic [7:0] imm;
    logic       immSel;
    logic [1:0] aluOp;
    logic [7:0] expSum;
    logic [7:0] expAnd;
    logic       expZero;
    logic [7:0] expRes;
  } aluVec_t;

  aluVec_t vecs [8];

  alu_mem_decode_unit dut (
    .clk(clk), .rst(rst), .rx(rx), .ry(ry), .imm(imm), .imm_sel(imm_sel),
    .alu_op(alu_op), .rd_sel(rd_sel), .d_sel(d_sel), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .sum_out(sum_out), .and_out(and_out), .zero(zero),
    .alu_res(alu_res), .mem_data(mem_data), .wb_data(wb_data), .save_en(save_en)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] aRx, input logic [7:0] aRy, input logic [7:0] aImm,
                               input logic aImmSel, input logic [1:0] aOp, input logic aRdSel,
                               input logic [2:0] aDsel, input logic aWe, input logic [7:0] aWdata,
                               input logic aRst);
    rx = aRx; ry = aRy; imm = aImm; imm_sel = aImmSel; alu_op = aOp; rd_sel = aRdSel;
    d_sel = aDsel; mem_we = aWe; mem_wdata = aWdata; rst = aRst;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 256; i++) modelMem[i] = 8'h00;
  endtask

  initial begin
    int y, s, a, res, z;
    vecs[0] = '{8'h05, 8'h03, 8'h00, 1'b0, 2'd1, 8'h08, 8'h01, 1'b0, 8'h08};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b0, 2'd1, 8'h00, 8'h01, 1'b0, 8'h00};
    vecs[2] = '{8'h3C, 8'h00, 8'h0F, 1'b1, 2'd0, 8'h4B, 8'h0C, 1'b0, 8'h0C};
    vecs[3] = '{8'h3C, 8'h00, 8'h0F, 1'b1, 2'd3, 8'h4B, 8'h0C, 1'b0, 8'h0F};
    vecs[4] = '{8'h3C, 8'h00, 8'h3C, 1'b1, 2'd2, 8'h78, 8'h3C, 1'b1, 8'h80};
    vecs[5] = '{8'h3C, 8'h00, 8'h3D, 1'b1, 2'd2, 8'h79, 8'h3C, 1'b0, 8'h00};
    vecs[6] = '{8'hAA, 8'hAA, 8'h55, 1'b0, 2'd2, 8'h54, 8'hAA, 1'b1, 8'h80};
    vecs[7] = '{8'h12, 8'h34, 8'h56, 1'b0, 2'd3, 8'h46, 8'h10, 1'b0, 8'h34};

    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1 checkOutput("save_en_in_reset", save_en, 8'h00);
    rst = 1'b0;

    // Combinational ALU vectors; no memory traffic, write-back from ALU.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rx, vecs[i].ry, vecs[i].imm, vecs[i].immSel, vecs[i].aluOp,
                    1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_sum", i), sum_out, vecs[i].expSum);
      checkOutput($sformatf("vec%0d_and", i), and_out, vecs[i].expAnd);
      checkOutput($sformatf("vec%0d_zero", i), {7'b0, zero}, {7'b0, vecs[i].expZero});
      checkOutput($sformatf("vec%0d_res", i), alu_res, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_wb", i), wb_data, vecs[i].expRes);
    end

    // One-cycle reset pulse, then read address 0x10.
    @(negedge clk);
    applyStimulus(8'h10, 8'h00, 8'h00, 1'b1, 2'd1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mem_after_reset", mem_data, 8'h00);
    checkOutput("wb_after_reset", wb_data, 8'h00);

    // Write 0xA5 to 0x10: old data before the edge, new data after.
    mem_we = 1'b1; mem_wdata = 8'hA5;
    #1 checkOutput("mem_before_write_edge", mem_data, 8'h00);
    @(negedge clk);
    mem_we = 1'b0;
    #1;
    checkOutput("mem_after_write_edge", mem_data, 8'hA5);
    checkOutput("wb_after_write_edge", wb_data, 8'hA5);
    rx = 8'h11;
    #1 checkOutput("mem_neighbour_untouched", mem_data, 8'h00);

    // Write and reset on the same edge: reset wins.
    rx = 8'h10; mem_we = 1'b1; mem_wdata = 8'h5A; rst = 1'b1;
    #1 checkOutput("mem_before_reset_write", mem_data, 8'hA5);
    @(negedge clk);
    rst = 1'b0; mem_we = 1'b0;
    #1 checkOutput("mem_reset_beats_write", mem_data, 8'h00);

    // Decoder sweep.
    for (int i = 0; i < 8; i++) begin
      d_sel = 3'(i);
      #1 checkOutput($sformatf("save_en_dsel%0d", i), save_en, 8'(1 << i));
    end
    d_sel = 3'd5; rst = 1'b1;
    #1 checkOutput("save_en_rst_dsel5", save_en, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    resetModel();

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                    1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 39) == 0));
      if (n % 3 == 0) rx = 8'($urandom_range(0, 7));
      y = imm_sel ? int'(imm) : int'(ry);
      s = (int'(rx) + y) % 256;
      a = int'(rx) & y;
      z = (int'(rx) == y) ? 1 : 0;
      case (int'(alu_op))
        0: res = a;
        1: res = s;
        2: res = z * 128;
        default: res = y;
      endcase
      #1;
      checkOutput("rnd_sum", sum_out, 8'(s));
      checkOutput("rnd_and", and_out, 8'(a));
      checkOutput("rnd_zero", {7'b0, zero}, 8'(z));
      checkOutput("rnd_res", alu_res, 8'(res));
      checkOutput("rnd_mem", mem_data, modelMem[res]);
      checkOutput("rnd_wb", wb_data, rd_sel ? modelMem[res] : 8'(res));
      checkOutput("rnd_save_en", save_en, rst ? 8'h00 : 8'(1 << int'(d_sel)));
      @(posedge clk);
      if (rst) resetModel();
      else if (mem_we) modelMem[res] = mem_wdata;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
